// File: rtl/ram_wave_sdp.sv
// Simple dual-port waveform RAM: one synchronous write port and one synchronous read port on a
// shared clock. Memory is preloaded with zeros.
module ram_wave_sdp #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OUTPUT_REG = 1,
    parameter string       INIT_FILE  = "wave.dat"
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned Depth = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [Depth] = '{default: '0};

    logic [DATA_WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read of the same array gives read-first behaviour on address collisions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem[rd_addr];
        end
    end

    if (OUTPUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] out_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                out_q <= '0;
            end else begin
                out_q <= rd_q;
            end
        end

        assign rd_data = out_q;
    end else begin : g_no_out_reg
        assign rd_data = rd_q;
    end

endmodule

// File: tb/tb_ram_wave_sdp.sv
// Randomised and directed bench for ram_wave_sdp against a cycle-history reference model.
module tb_ram_wave_sdp;

    localparam int AW    = 14;
    localparam int DW    = 8;
    localparam int OREG  = 1;
    localparam int LAT   = (OREG != 0) ? 2 : 1;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_wave_sdp #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .OUTPUT_REG(OREG),
        .INIT_FILE ("wave.dat")
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: memory contents plus, per edge, whether reset was high and what
    // the addressed word held before that edge's write.
    logic [DW-1:0] mem_m [DEPTH];
    bit            rst_h [4];
    logic [DW-1:0] val_h [4];
    int            nedges = 0;
    logic [DW-1:0] exp_q;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    end

    always @(posedge clk) begin
        int  s;
        bit  ok;
        s        = nedges % 4;
        rst_h[s] = (rst_n === 1'b1);
        val_h[s] = rst_h[s] ? mem_m[rd_addr] : '0;
        if (rst_h[s] && wr_en) mem_m[wr_addr] = wr_data;
        nedges++;
        if (nedges >= LAT) begin
            ok = 1'b1;
            for (int k = 0; k < LAT; k++) ok = ok & rst_h[(nedges - 1 - k) % 4];
            exp_q = ok ? val_h[(nedges - LAT) % 4] : '0;
        end
    end

    always @(negedge clk) begin
        if (nedges >= LAT) check("model", rd_data, exp_q);
    end

    task automatic cyc(input logic r, input logic w, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [AW-1:0] ra);
        @(negedge clk);
        rst_n   = r;
        wr_en   = w;
        wr_addr = wa;
        wr_data = wd;
        rd_addr = ra;
    endtask

    logic [AW-1:0] wrap_a [4];
    logic [DW-1:0] wrap_d [4];

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;

        // Reset hold with a write attempt to address 5.
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1, AW'(5), 8'hAA, AW'(5));
            check("reset_hold", rd_data, 8'h00);
        end
        cyc(1'b1, 1'b0, '0, '0, AW'(5));
        repeat (LAT) cyc(1'b1, 1'b0, '0, '0, '0);
        check("mem5_untouched", rd_data, 8'h00);

        // Read-during-write at address 100.
        cyc(1'b1, 1'b1, AW'(100), 8'h11, '0);
        cyc(1'b1, 1'b1, AW'(100), 8'h22, AW'(100));
        cyc(1'b1, 1'b0, '0, '0, AW'(100));
        repeat (LAT - 1) cyc(1'b1, 1'b0, '0, '0, '0);
        check("rdw_old", rd_data, 8'h11);
        cyc(1'b1, 1'b0, '0, '0, '0);
        check("rdw_new", rd_data, 8'h22);

        // Address wrap, back to back, with exact latency.
        wrap_a = '{AW'(DEPTH - 2), AW'(DEPTH - 1), AW'(0), AW'(1)};
        wrap_d = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, wrap_a[i], wrap_d[i], '0);
        for (int i = 0; i < 4 + LAT; i++) begin
            cyc(1'b1, 1'b0, '0, '0, (i < 4) ? wrap_a[i] : AW'(0));
            if (i >= LAT) check("wrap_seq", rd_data, wrap_d[i - LAT]);
        end

        // Full write sweep with random concurrent reads.
        for (int k = 0; k < DEPTH; k++) begin
            cyc(1'b1, 1'b1, AW'(k), 8'hFF - k[7:0], AW'($urandom));
        end

        // Read sweep with a one-cycle mid-stream reset pulse.
        for (int k = 0; k < DEPTH; k++) begin
            cyc((k != 5000), 1'b0, '0, '0, AW'(k));
            if (k == 300) check("sweep_pin", rd_data, 8'hFF - 8'((300 - LAT) % 256));
            if (k == 5001) check("midreset_zero", rd_data, 8'h00);
        end

        // Random traffic with occasional reset.
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 99) != 0), 1'($urandom), AW'($urandom_range(0, 63)),
                DW'($urandom), AW'($urandom_range(0, 63)));
        end
        repeat (LAT + 1) cyc(1'b1, 1'b0, '0, '0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
